// File: rtl/fp_to_int_scheduler.sv
// rtl/fp_to_int_scheduler.sv - round-robin scheduler sharing one Float32->Int32 converter among requesters
module fp_to_int_scheduler #(
    parameter int NUM_REQ = 4
) (
    input  logic                   aClock,
    input  logic                   aResetN,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*32-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_data,
    output logic                   rsp_ovf,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic                   busy,
    output logic [31:0]            conv_count
);
    localparam int TAG_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        RESPOND
    } stateT;

    stateT            state;
    logic [TAG_W-1:0] rrPtr;
    logic [TAG_W-1:0] tag;
    logic [31:0]      operand;
    logic [TAG_W-1:0] grant;
    logic             grantFound;

    function automatic logic [TAG_W-1:0] wrapIdx(input int v);
        return TAG_W'(v % NUM_REQ);
    endfunction

    // Returns {ovf, result}; truncates toward zero and saturates out-of-range values.
    function automatic logic [32:0] f2i(input logic [31:0] f);
        logic        sgn;
        logic [7:0]  e;
        logic [22:0] m;
        logic [31:0] mag;
        sgn = f[31];
        e   = f[30:23];
        m   = f[22:0];
        mag = {8'h00, 1'b1, m};
        if (e < 8'd127)
            return 33'd0;
        if (e <= 8'd157) begin
            if (e <= 8'd150)
                mag = mag >> (8'd150 - e);
            else
                mag = mag << (e - 8'd150);
            return {1'b0, sgn ? -mag : mag};
        end
        if (e == 8'hFF && m != '0)
            return {1'b1, 32'h7FFF_FFFF};
        if (e == 8'd158 && sgn && m == '0)
            return {1'b0, 32'h8000_0000};
        return {1'b1, sgn ? 32'h8000_0000 : 32'h7FFF_FFFF};
    endfunction

    // Walk from the farthest offset down so the requester closest to rrPtr wins.
    always_comb begin
        grant      = '0;
        grantFound = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[wrapIdx(int'(rrPtr) + k)]) begin
                grant      = wrapIdx(int'(rrPtr) + k);
                grantFound = 1'b1;
            end
        end
    end

    assign req_ready = (state == IDLE && grantFound) ? (NUM_REQ'(1) << grant) : '0;

    always_ff @(posedge aClock or negedge aResetN) begin
        if (!aResetN) begin
            state      <= IDLE;
            rrPtr      <= '0;
            tag        <= '0;
            operand    <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            rsp_ovf    <= 1'b0;
            busy       <= 1'b0;
            conv_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantFound) begin
                        operand <= req_data[32*int'(grant) +: 32];
                        tag     <= grant;
                        rrPtr   <= wrapIdx(int'(grant) + 1);
                        busy    <= 1'b1;
                        state   <= CONVERT;
                    end
                end
                CONVERT: begin
                    {rsp_ovf, rsp_data} <= f2i(operand);
                    rsp_valid           <= NUM_REQ'(1) << tag;
                    state               <= RESPOND;
                end
                RESPOND: begin
                    if (rsp_ready[tag]) begin
                        rsp_valid  <= '0;
                        conv_count <= conv_count + 32'd1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_to_int_scheduler.sv
// tb/tb_fp_to_int_scheduler.sv - directed self-checking bench for fp_to_int_scheduler
module tb_fp_to_int_scheduler;
    localparam int NUM_REQ = 4;

    logic                  aClock;
    logic                  aResetN;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_data;
    logic                  rsp_ovf;
    logic [NUM_REQ-1:0]    rsp_ready;
    logic                  busy;
    logic [31:0]           conv_count;

    int vecs;
    int errs;

    fp_to_int_scheduler #(.NUM_REQ(NUM_REQ)) dut (
        .aClock    (aClock),
        .aResetN   (aResetN),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ovf   (rsp_ovf),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .conv_count(conv_count)
    );

    initial aClock = 1'b0;
    always #5 aClock = ~aClock;

    task automatic tick();
        @(posedge aClock);
        #1;
    endtask

    task automatic chk(input string tagName, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tagName, obs, exp);
        end
    endtask

    // Single request from requester idx with rsp_ready all high; checks grant, latency and result.
    task automatic runConv(input int idx, input logic [31:0] op, input logic [31:0] expData,
                           input logic expOvf, input string tagName);
        req_valid                = '0;
        req_valid[idx]           = 1'b1;
        req_data[32*idx +: 32]   = op;
        #1;
        chk({tagName, "_req_ready"}, 32'(req_ready), 32'(1 << idx));
        tick();
        req_valid = '0;
        tick();
        chk({tagName, "_rsp_valid"}, 32'(rsp_valid), 32'(1 << idx));
        chk({tagName, "_data"}, rsp_data, expData);
        chk({tagName, "_ovf"}, 32'(rsp_ovf), 32'(expOvf));
        tick();
    endtask

    initial begin
        vecs      = 0;
        errs      = 0;
        aResetN   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = '0;
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_count", conv_count, 32'h0);
        aResetN   = 1'b1;
        rsp_ready = '1;
        tick();

        // 1.5 from requester 0: accept cycle 0, response cycle 2
        req_valid    = 4'b0001;
        req_data[31:0] = 32'h3FC0_0000;
        #1;
        chk("t1_ready_c0", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk("t1_busy_c1", 32'(busy), 32'h1);
        chk("t1_rsp_valid_c1", 32'(rsp_valid), 32'h0);
        tick();
        chk("t1_rsp_valid_c2", 32'(rsp_valid), 32'h1);
        chk("t1_data", rsp_data, 32'h0000_0001);
        chk("t1_ovf", 32'(rsp_ovf), 32'h0);
        tick();
        chk("t1_count", conv_count, 32'd1);
        chk("t1_idle", 32'(busy), 32'h0);

        // Reset in IDLE to bring rr pointer back to 0 before the round-robin check
        aResetN = 1'b0;
        tick();
        aResetN = 1'b1;
        tick();

        req_data  = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3FC0_0000};
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
            tick();
            tick();
            chk($sformatf("rr_rsp%0d", k), 32'(rsp_valid), 32'(1 << (k % 4)));
            chk($sformatf("rr_data%0d", k), rsp_data, 32'((k % 4) + 1));
            tick();
        end
        req_valid = '0;
        chk("rr_count5", conv_count, 32'd5);

        // Requester 2 back-pressured for 10 cycles while others are requesting
        rsp_ready              = 4'b1011;
        req_valid              = 4'b0100;
        req_data[64 +: 32]     = 32'hC2F6_E979;
        #1;
        chk("bp_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b1011;
        tick();
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("bp_valid%0d", k), 32'(rsp_valid), 32'h4);
            chk($sformatf("bp_data%0d", k), rsp_data, 32'hFFFF_FF85);
            chk($sformatf("bp_noready%0d", k), 32'(req_ready), 32'h0);
            chk($sformatf("bp_busy%0d", k), 32'(busy), 32'h1);
            tick();
        end
        chk("bp_count_hold", conv_count, 32'd5);
        rsp_ready = 4'b1111;
        req_valid = '0;
        tick();
        chk("bp_count", conv_count, 32'd6);
        chk("bp_released", 32'(rsp_valid), 32'h0);

        runConv(1, 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, "pos2p31");
        runConv(1, 32'hCF00_0000, 32'h8000_0000, 1'b0, "neg2p31");
        runConv(1, 32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, "nan");
        runConv(1, 32'h0000_0001, 32'h0000_0000, 1'b0, "denorm");
        runConv(1, 32'hBF00_0000, 32'h0000_0000, 1'b0, "neghalf");
        runConv(3, 32'hC2F6_E979, 32'hFFFF_FF85, 1'b0, "neg123");
        runConv(0, 32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, "maxe157");
        runConv(2, 32'hFF80_0000, 32'h8000_0000, 1'b1, "neginf");
        runConv(0, 32'h8000_0000, 32'h0000_0000, 1'b0, "negzero");
        runConv(2, 32'hCF00_0001, 32'h8000_0000, 1'b1, "negovf");
        runConv(3, 32'h3F80_0000, 32'h0000_0001, 1'b0, "one");
        chk("ops_count", conv_count, 32'd17);

        // Reset during RESPOND: outputs clear asynchronously and rr pointer returns to 0
        rsp_ready = '0;
        runConvStart: begin
            req_valid          = 4'b0010;
            req_data[32 +: 32] = 32'h4000_0000;
            tick();
            req_valid = '0;
            tick();
            chk("rr_pre_valid", 32'(rsp_valid), 32'h2);
        end
        #2;
        aResetN = 1'b0;
        #1;
        chk("arst_valid", 32'(rsp_valid), 32'h0);
        chk("arst_data", rsp_data, 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_count", conv_count, 32'h0);
        tick();
        aResetN   = 1'b1;
        rsp_ready = '1;
        tick();
        req_valid          = 4'b1010;
        req_data[32 +: 32] = 32'h4000_0000;
        req_data[96 +: 32] = 32'h4080_0000;
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        tick();
        chk("post_rst_rsp", 32'(rsp_valid), 32'h2);
        chk("post_rst_data", rsp_data, 32'h0000_0002);
        tick();
        chk("post_rst_count", conv_count, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
